// File: rtl/rr_arbiter4_enc.sv
// Four-way round-robin arbiter with one-hot and binary grant outputs.
// Holders keep the grant while requesting, bounded by MAX_BURST.
module rr_arbiter4_enc #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam bit             LIMIT = (MAX_BURST != 0);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  logic [3:0] cand;
  logic [1:0] start;
  logic [1:0] k;
  logic       win_found;
  logic [1:0] win_idx;
  logic       hand_off;
  logic       at_limit;

  // Current holder is masked out so the search only sees other requesters.
  always_comb begin
    cand      = req & ~gnt_q;
    start     = (state_q == GRANT) ? idx_q + 2'd1 : last_q + 2'd1;
    win_found = 1'b0;
    win_idx   = 2'd0;
    k         = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      k = start + 2'(i);
      if (cand[k]) begin
        win_found = 1'b1;
        win_idx   = k;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    at_limit = LIMIT && (cnt_q == MAX_C);
    hand_off = !req[idx_q] || (at_limit && win_found);
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_idx;
          idx_d   = win_idx;
          cnt_d   = ONE_C;
        end
      end
      GRANT: begin
        if (hand_off) begin
          last_d = idx_q;
          if (win_found) begin
            gnt_d = 4'b0001 << win_idx;
            idx_d = win_idx;
            cnt_d = ONE_C;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            idx_d   = 2'd0;
            cnt_d   = '0;
          end
        end else if (LIMIT && !at_limit) begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == GRANT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter4_enc.sv
// Directed bench for rr_arbiter4_enc with burst limits 4, 1 and 0.
module tb_rr_arbiter4_enc;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] g4, g1, g0;
  logic [1:0] i4, i1, i0;
  logic       v4, v1, v0;
  int         pass;
  int         total;

  rr_arbiter4_enc #(.MAX_BURST(4), .CNT_W(3)) u4 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(g4), .gnt_idx(i4), .gnt_valid(v4)
  );

  rr_arbiter4_enc #(.MAX_BURST(1), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(g1), .gnt_idx(i1), .gnt_valid(v1)
  );

  rr_arbiter4_enc #(.MAX_BURST(0), .CNT_W(3)) u0 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(g0), .gnt_idx(i0), .gnt_valid(v0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    tick();
    tick();
    total++;
    if ({g4, i4, v4} !== 7'b0000_00_0)
      $display("FAIL reset_u4 got %b exp %b", {g4, i4, v4}, 7'b0000_00_0);
    else pass++;
    total++;
    if ({g1, i1, v1} !== 7'b0000_00_0)
      $display("FAIL reset_u1 got %b exp %b", {g1, i1, v1}, 7'b0000_00_0);
    else pass++;
    rst = 1'b0;
    tick();
    total++;
    if ({g4, i4, v4} !== 7'b0001_00_1)
      $display("FAIL reset_release got %b exp %b", {g4, i4, v4}, 7'b0001_00_1);
    else pass++;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({g4, i4, v4} !== 7'b0100_10_1)
        $display("FAIL single_c%0d got %b exp %b", c, {g4, i4, v4}, 7'b0100_10_1);
      else pass++;
    end
    req = 4'b0000;
    tick();
    total++;
    if ({g4, i4, v4} !== 7'b0000_00_0)
      $display("FAIL single_drop got %b exp %b", {g4, i4, v4}, 7'b0000_00_0);
    else pass++;
  endtask

  task automatic test_fairness();
    logic [6:0] exp [6];
    exp = '{7'b0001_00_1, 7'b0010_01_1, 7'b0100_10_1,
            7'b1000_11_1, 7'b0001_00_1, 7'b0010_01_1};
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if ({g1, i1, v1} !== exp[c])
        $display("FAIL fair_c%0d got %b exp %b", c, {g1, i1, v1}, exp[c]);
      else pass++;
    end
  endtask

  task automatic test_burst();
    logic [3:0] e;
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 9; c++) begin
      tick();
      e = (c < 4 || c == 8) ? 4'b0001 : 4'b0010;
      total++;
      if (g4 !== e)
        $display("FAIL burst_c%0d got %b exp %b", c, g4, e);
      else pass++;
      total++;
      if (g0 !== 4'b0001)
        $display("FAIL unlim_c%0d got %b exp %b", c, g0, 4'b0001);
      else pass++;
    end
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if ({g4, i4, v4} !== 7'b0001_00_1)
        $display("FAIL alone_c%0d got %b exp %b", c, {g4, i4, v4}, 7'b0001_00_1);
      else pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0010;
    tick();
    total++;
    if ({g4, i4, v4} !== 7'b0010_01_1)
      $display("FAIL b2b_start got %b exp %b", {g4, i4, v4}, 7'b0010_01_1);
    else pass++;
    req = 4'b0110;
    tick();
    total++;
    if ({g4, i4, v4} !== 7'b0010_01_1)
      $display("FAIL b2b_hold got %b exp %b", {g4, i4, v4}, 7'b0010_01_1);
    else pass++;
    req = 4'b0100;
    tick();
    total++;
    if ({g4, i4, v4} !== 7'b0100_10_1)
      $display("FAIL b2b_handoff got %b exp %b", {g4, i4, v4}, 7'b0100_10_1);
    else pass++;
    req = 4'b0000;
    tick();
    total++;
    if ({g4, i4, v4} !== 7'b0000_00_0)
      $display("FAIL b2b_idle got %b exp %b", {g4, i4, v4}, 7'b0000_00_0);
    else pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1000;
    tick();
    tick();
    total++;
    if ({g4, i4, v4} !== 7'b1000_11_1)
      $display("FAIL mid_pre got %b exp %b", {g4, i4, v4}, 7'b1000_11_1);
    else pass++;
    rst = 1'b1;
    req = 4'b1001;
    tick();
    total++;
    if ({g4, i4, v4} !== 7'b0000_00_0)
      $display("FAIL mid_rst got %b exp %b", {g4, i4, v4}, 7'b0000_00_0);
    else pass++;
    rst = 1'b0;
    tick();
    total++;
    if ({g4, i4, v4} !== 7'b0001_00_1)
      $display("FAIL mid_post got %b exp %b", {g4, i4, v4}, 7'b0001_00_1);
    else pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    pass  = 0;
    total = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    test_reset();
    test_single();
    test_fairness();
    test_burst();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
